// File: rtl/pong_pkg.sv
// Shared pong constants: screen geometry, RGB565 colours and the frame scheduler state type.
package pong_pkg;

    localparam int unsigned H_RES      = 240;
    localparam int unsigned V_RES      = 135;
    localparam int unsigned NUM_PIXELS = H_RES * V_RES;
    localparam int unsigned PIX_W      = 16;
    localparam int unsigned RGB_W      = 16;

    typedef logic [RGB_W-1:0] rgb565_t;

    localparam rgb565_t RGB565_WHITE = 16'hFFFF;
    localparam rgb565_t RGB565_BLACK = 16'h0000;

    typedef enum logic [2:0] {
        IDLE,
        WIN_REQ,
        STREAM,
        TICK,
        SETTLE
    } sched_state_t;

endpackage

// File: rtl/frame_scheduler_if.sv
// Pixel-side bundle of the frame scheduler: window request, game pixel lookup and RGB565 stream.
interface frame_scheduler_if;
    import pong_pkg::*;

    logic             win_req;
    logic             win_ack;
    logic [PIX_W-1:0] pixelcnt;
    logic             pix_in;
    logic             px_valid;
    rgb565_t          px_data;
    logic             px_ready;

    modport master (
        output win_req, pixelcnt, px_valid, px_data,
        input  win_ack, pix_in, px_ready
    );

    modport slave (
        input  win_req, pixelcnt, px_valid, px_data,
        output win_ack, pix_in, px_ready
    );

endinterface

// File: rtl/frame_tick_gen.sv
// Post-frame timer: holds frame_clk high for TICK_LEN cycles, then counts SETTLE_LEN quiet cycles.
module frame_tick_gen #(
    parameter int unsigned TICK_LEN   = 2,
    parameter int unsigned SETTLE_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    output logic o_frame_clk,
    output logic o_tick_end_c,
    output logic o_done_c
);

    localparam int unsigned CNT_MAX = (TICK_LEN > SETTLE_LEN) ? TICK_LEN : SETTLE_LEN;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        T_IDLE,
        T_TICK,
        T_SETTLE
    } tick_phase_t;

    tick_phase_t      r_phase;
    logic [CNT_W-1:0] r_cnt;
    logic             r_frame_clk;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase     <= T_IDLE;
            r_cnt       <= '0;
            r_frame_clk <= 1'b0;
        end else begin
            case (r_phase)
                T_IDLE: begin
                    if (i_start) begin
                        r_phase     <= T_TICK;
                        r_cnt       <= CNT_W'(TICK_LEN - 1);
                        r_frame_clk <= 1'b1;
                    end
                end
                T_TICK: begin
                    if (r_cnt == '0) begin
                        r_phase     <= T_SETTLE;
                        r_cnt       <= CNT_W'(SETTLE_LEN - 1);
                        r_frame_clk <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                T_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_phase <= T_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_phase     <= T_IDLE;
                    r_cnt       <= '0;
                    r_frame_clk <= 1'b0;
                end
            endcase
        end
    end

    assign o_frame_clk  = r_frame_clk;
    assign o_tick_end_c = (r_phase == T_TICK)   && (r_cnt == '0);
    assign o_done_c     = (r_phase == T_SETTLE) && (r_cnt == '0);

endmodule

// File: rtl/frame_scheduler.sv
// Sequences one LCD frame at a time: window setup, pixel sweep into RGB565 words, then the game-state tick.
module frame_scheduler #(
    parameter int unsigned      H_RES      = pong_pkg::H_RES,
    parameter int unsigned      V_RES      = pong_pkg::V_RES,
    parameter int unsigned      FRAME_DIV  = 1,
    parameter int unsigned      TICK_LEN   = 2,
    parameter int unsigned      SETTLE_LEN = 4,
    parameter logic [15:0]      FG_COLOR   = pong_pkg::RGB565_WHITE,
    parameter logic [15:0]      BG_COLOR   = pong_pkg::RGB565_BLACK
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                lcd_ready,
    frame_scheduler_if.master   px_if,
    output logic                frame_clk,
    output logic                busy
);
    import pong_pkg::*;

    localparam int unsigned LAST_PIX = H_RES * V_RES - 1;
    localparam int unsigned DIV_W    = $clog2(FRAME_DIV + 1);

    sched_state_t     r_state;
    logic             r_win_req;
    logic             r_px_valid;
    logic             r_busy;
    logic [PIX_W-1:0] r_pixelcnt;
    logic [DIV_W-1:0] r_frame_cnt;

    logic w_xfer;
    logic w_last;
    logic w_div_last;
    logic w_tick_start;
    logic w_tick_end;
    logic w_settle_done;

    assign w_xfer       = r_px_valid && px_if.px_ready;
    assign w_last       = (r_pixelcnt == PIX_W'(LAST_PIX));
    assign w_div_last   = (r_frame_cnt == DIV_W'(FRAME_DIV - 1));
    assign w_tick_start = (r_state == STREAM) && w_xfer && w_last && w_div_last;

    // Frame sequencer; a reset discards any partial frame on the spot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_win_req   <= 1'b0;
            r_px_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_pixelcnt  <= '0;
            r_frame_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (enable && lcd_ready) begin
                        r_state   <= WIN_REQ;
                        r_win_req <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                WIN_REQ: begin
                    if (px_if.win_ack) begin
                        r_state    <= STREAM;
                        r_win_req  <= 1'b0;
                        r_px_valid <= 1'b1;
                    end
                end
                STREAM: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_pixelcnt <= '0;
                            r_px_valid <= 1'b0;
                            if (w_div_last) begin
                                r_frame_cnt <= '0;
                                r_state     <= TICK;
                            end else begin
                                r_frame_cnt <= r_frame_cnt + DIV_W'(1);
                                if (enable) begin
                                    r_state   <= WIN_REQ;
                                    r_win_req <= 1'b1;
                                end else begin
                                    r_state <= IDLE;
                                    r_busy  <= 1'b0;
                                end
                            end
                        end else begin
                            r_pixelcnt <= r_pixelcnt + PIX_W'(1);
                        end
                    end
                end
                TICK: begin
                    if (w_tick_end) begin
                        r_state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (w_settle_done) begin
                        if (enable && lcd_ready) begin
                            r_state   <= WIN_REQ;
                            r_win_req <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_win_req  <= 1'b0;
                    r_px_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_pixelcnt <= '0;
                end
            endcase
        end
    end

    frame_tick_gen #(
        .TICK_LEN   (TICK_LEN),
        .SETTLE_LEN (SETTLE_LEN)
    ) u_tick_gen (
        .clk          (clk),
        .rst          (rst),
        .i_start      (w_tick_start),
        .o_frame_clk  (frame_clk),
        .o_tick_end_c (w_tick_end),
        .o_done_c     (w_settle_done)
    );

    assign px_if.win_req  = r_win_req;
    assign px_if.px_valid = r_px_valid;
    assign px_if.pixelcnt = r_pixelcnt;
    assign px_if.px_data  = px_if.pix_in ? FG_COLOR : BG_COLOR;
    assign busy           = r_busy;

endmodule

// File: tb/tb_frame_scheduler.sv
// Bench for frame_scheduler: full-size directed instance plus a small randomized FRAME_DIV=2 instance.
module tb_frame_scheduler;

    localparam int M_H    [2] = '{240, 20};
    localparam int M_V    [2] = '{135, 15};
    localparam int M_DIV  [2] = '{1, 2};
    localparam int M_TICK [2] = '{2, 3};
    localparam int M_SET  [2] = '{4, 2};
    localparam int NPIX_LIT [2] = '{32400, 300};

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, en_a, lrdy_a, pxr_a, ack_auto_a, stray_a, fc_a, busy_a, done_a;
    logic rst_b, en_b, lrdy_b, pxr_b, ack_b, fc_b, busy_b, done_b;
    logic fin_req;

    // Game-logic stand-in: which pixel indices are foreground.
    function automatic logic game_pix(input int k, input int idx);
        if (k == 0) return (idx >= 100) && (idx <= 110);
        return ((idx * 5) % 11) < 4;
    endfunction

    function automatic logic [15:0] colour(input logic p);
        return p ? 16'hFFFF : 16'h0000;
    endfunction

    frame_scheduler_if if_a ();
    frame_scheduler_if if_b ();

    assign if_a.win_ack  = ack_auto_a | stray_a;
    assign if_a.px_ready = pxr_a;
    assign if_a.pix_in   = game_pix(0, int'(if_a.pixelcnt));
    assign if_b.win_ack  = ack_b;
    assign if_b.px_ready = pxr_b;
    assign if_b.pix_in   = game_pix(1, int'(if_b.pixelcnt));

    frame_scheduler #(
        .H_RES(M_H[0]), .V_RES(M_V[0]), .FRAME_DIV(M_DIV[0]),
        .TICK_LEN(M_TICK[0]), .SETTLE_LEN(M_SET[0]),
        .FG_COLOR(16'hFFFF), .BG_COLOR(16'h0000)
    ) dut_a (
        .clk(clk), .rst(rst_a), .enable(en_a), .lcd_ready(lrdy_a),
        .px_if(if_a.master), .frame_clk(fc_a), .busy(busy_a)
    );

    frame_scheduler #(
        .H_RES(M_H[1]), .V_RES(M_V[1]), .FRAME_DIV(M_DIV[1]),
        .TICK_LEN(M_TICK[1]), .SETTLE_LEN(M_SET[1]),
        .FG_COLOR(16'hFFFF), .BG_COLOR(16'h0000)
    ) dut_b (
        .clk(clk), .rst(rst_b), .enable(en_b), .lcd_ready(lrdy_b),
        .px_if(if_b.master), .frame_clk(fc_b), .busy(busy_b)
    );

    logic        s_rst [2], s_en [2], s_lrdy [2], s_ack [2], s_pxr [2];
    logic        o_wr [2], o_pv [2], o_fc [2], o_busy [2];
    logic [15:0] o_cnt [2], o_data [2];

    assign s_rst[0] = rst_a;  assign s_rst[1] = rst_b;
    assign s_en[0]  = en_a;   assign s_en[1]  = en_b;
    assign s_lrdy[0] = lrdy_a; assign s_lrdy[1] = lrdy_b;
    assign s_ack[0] = if_a.win_ack;  assign s_ack[1] = if_b.win_ack;
    assign s_pxr[0] = pxr_a;  assign s_pxr[1] = pxr_b;
    assign o_wr[0]  = if_a.win_req;  assign o_wr[1]  = if_b.win_req;
    assign o_pv[0]  = if_a.px_valid; assign o_pv[1]  = if_b.px_valid;
    assign o_cnt[0] = if_a.pixelcnt; assign o_cnt[1] = if_b.pixelcnt;
    assign o_data[0] = if_a.px_data; assign o_data[1] = if_b.px_data;
    assign o_fc[0]  = fc_a;   assign o_fc[1]  = fc_b;
    assign o_busy[0] = busy_a; assign o_busy[1] = busy_b;

    // Stimulus A: reset mid-stream, nominal frame, then enable drop and a stray ack in idle.
    initial begin : stim_a
        int n;
        rst_a = 1'b1; en_a = 1'b0; lrdy_a = 1'b0; pxr_a = 1'b0; stray_a = 1'b0; done_a = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_a = 1'b0;
        @(posedge clk);
        #1 en_a = 1'b1; lrdy_a = 1'b1; pxr_a = 1'b1;
        n = 0;
        while (!(if_a.px_valid && if_a.pixelcnt == 16'd5000) && n < 8000) begin
            @(posedge clk); #1; n++;
        end
        rst_a = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_a = 1'b0;
        n = 0;
        while (!fc_a && n < 40000) begin
            @(posedge clk); #1; n++;
        end
        n = 0;
        while (!(if_a.px_valid && if_a.pixelcnt == 16'd1000) && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        en_a = 1'b0;
        n = 0;
        while (busy_a && n < 40000) begin
            @(posedge clk); #1; n++;
        end
        repeat (3) @(posedge clk);
        #1 stray_a = 1'b1;
        @(posedge clk);
        #1 stray_a = 1'b0;
        repeat (10) @(posedge clk);
        #1 done_a = 1'b1;
    end

    // Window-setup responder for A: acknowledge two cycles after win_req rises.
    initial begin : resp_a
        int age;
        age = 0;
        ack_auto_a = 1'b0;
        forever begin
            @(posedge clk); #1;
            ack_auto_a = 1'b0;
            if (if_a.win_req) begin
                age++;
                if (age == 3) ack_auto_a = 1'b1;
            end else begin
                age = 0;
            end
        end
    end

    // Stimulus B: random backpressure and random ack delay over four frames.
    initial begin : stim_b
        int age, tgt, starts;
        rst_b = 1'b1; en_b = 1'b0; lrdy_b = 1'b1; pxr_b = 1'b0; ack_b = 1'b0; done_b = 1'b0;
        age = 0; tgt = 1; starts = 0;
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b0; en_b = 1'b1;
        for (int cyc = 0; cyc < 20000 && !done_b; cyc++) begin
            @(posedge clk); #1;
            pxr_b = ($urandom_range(0, 1) == 1);
            ack_b = 1'b0;
            if (if_b.win_req) begin
                age++;
                if (age == 1) tgt = int'($urandom_range(1, 4));
                if (age == tgt) begin
                    ack_b = 1'b1;
                    starts++;
                    if (starts == 4) en_b = 1'b0;
                end
            end else begin
                age = 0;
            end
            if (starts == 4 && !busy_b && !ack_b) done_b = 1'b1;
        end
        done_b = 1'b1;
    end

    initial begin : watchdog
        fin_req = 1'b0;
        for (int c = 0; c < 90000 && !(done_a && done_b); c++) @(posedge clk);
        fin_req = 1'b1;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
        else
            n_pass++;
    endtask

    // Reference timeline: 0 idle, 1 window request, 2 streaming, 3 post-frame (tick then settle).
    int m_mode [2]   = '{0, 0};
    int m_idx [2]    = '{0, 0};
    int m_frames [2] = '{0, 0};
    int m_post [2]   = '{0, 0};

    logic prev_rst [2]  = '{1'b0, 1'b0};
    int   fc_run [2]    = '{0, 0};
    int   gap [2]       = '{0, 0};
    logic in_gap [2]    = '{1'b0, 1'b0};
    int   xfers [2]     = '{0, 0};
    int   fr_done [2]   = '{0, 0};
    int   pulses [2]    = '{0, 0};
    logic after_end [2] = '{1'b0, 1'b0};
    logic fin_done      = 1'b0;

    always @(negedge clk) begin : compare
        for (int k = 0; k < 2; k++) begin
            logic e_wr, e_pv, e_fc, e_busy;
            int   e_cnt;
            e_wr   = (m_mode[k] == 1);
            e_pv   = (m_mode[k] == 2);
            e_busy = (m_mode[k] != 0);
            e_fc   = (m_mode[k] == 3) && (m_post[k] > M_SET[k]);
            e_cnt  = (m_mode[k] == 2) ? m_idx[k] : 0;
            chk("win_req",   k, 32'(o_wr[k]),   32'(e_wr));
            chk("px_valid",  k, 32'(o_pv[k]),   32'(e_pv));
            chk("frame_clk", k, 32'(o_fc[k]),   32'(e_fc));
            chk("busy",      k, 32'(o_busy[k]), 32'(e_busy));
            chk("pixelcnt",  k, 32'(o_cnt[k]),  32'(e_cnt));
            if (e_pv) chk("px_data", k, 32'(o_data[k]), 32'(colour(game_pix(k, m_idx[k]))));

            // Hand-computed pins independent of the timeline.
            if (prev_rst[k]) begin
                chk("rst_px_valid",  k, 32'(o_pv[k]),   32'd0);
                chk("rst_pixelcnt",  k, 32'(o_cnt[k]),  32'd0);
                chk("rst_win_req",   k, 32'(o_wr[k]),   32'd0);
                chk("rst_frame_clk", k, 32'(o_fc[k]),   32'd0);
                chk("rst_busy",      k, 32'(o_busy[k]), 32'd0);
                fc_run[k] = 0; in_gap[k] = 1'b0; after_end[k] = 1'b0;
            end
            prev_rst[k] = s_rst[k];

            if (after_end[k]) begin
                if (k == 1 && (fr_done[k] % 2) == 1) chk("direct_win_req", k, 32'(o_wr[k]), 32'd1);
                else chk("tick_follows", k, 32'(o_fc[k]), 32'd1);
                after_end[k] = 1'b0;
            end

            if (o_fc[k] === 1'b1) begin
                fc_run[k]++;
                chk("fc_quiet", k, 32'({o_pv[k], o_wr[k]}), 32'd0);
            end else if (fc_run[k] > 0) begin
                chk("tick_len", k, 32'(fc_run[k]), 32'(M_TICK[k]));
                fc_run[k] = 0; pulses[k]++; gap[k] = 0; in_gap[k] = 1'b1;
            end
            if (in_gap[k]) begin
                if (o_busy[k] && !o_wr[k] && !o_pv[k] && !o_fc[k]) begin
                    gap[k]++;
                    chk("settle_cnt_zero", k, 32'(o_cnt[k]), 32'd0);
                end else begin
                    chk("settle_len", k, 32'(gap[k]), 32'(M_SET[k]));
                    in_gap[k] = 1'b0;
                end
            end

            if (k == 0 && o_pv[k]) begin
                if (o_cnt[k] == 16'd105) chk("colour_fg", k, 32'(o_data[k]), 32'h0000_FFFF);
                if (o_cnt[k] == 16'd111) chk("colour_bg", k, 32'(o_data[k]), 32'h0000_0000);
            end

            if (s_rst[k]) begin
                xfers[k] = 0;
            end else if (o_pv[k] && s_pxr[k]) begin
                xfers[k]++;
                if (int'(o_cnt[k]) == NPIX_LIT[k] - 1) begin
                    chk("frame_xfers", k, 32'(xfers[k]), 32'(NPIX_LIT[k]));
                    xfers[k] = 0; fr_done[k]++; after_end[k] = 1'b1;
                end
            end

            // Advance the timeline with the inputs the next clock edge will see.
            if (s_rst[k]) begin
                m_mode[k] = 0; m_idx[k] = 0; m_frames[k] = 0; m_post[k] = 0;
            end else begin
                case (m_mode[k])
                    0: if (s_en[k] && s_lrdy[k]) m_mode[k] = 1;
                    1: if (s_ack[k]) begin m_mode[k] = 2; m_idx[k] = 0; end
                    2: if (s_pxr[k]) begin
                        if (m_idx[k] == M_H[k] * M_V[k] - 1) begin
                            m_idx[k] = 0;
                            m_frames[k]++;
                            if (m_frames[k] % M_DIV[k] == 0) begin
                                m_mode[k] = 3;
                                m_post[k] = M_TICK[k] + M_SET[k];
                            end else begin
                                m_mode[k] = s_en[k] ? 1 : 0;
                            end
                        end else begin
                            m_idx[k]++;
                        end
                    end
                    default: begin
                        m_post[k]--;
                        if (m_post[k] == 0) m_mode[k] = (s_en[k] && s_lrdy[k]) ? 1 : 0;
                    end
                endcase
            end
        end

        if (fin_req && !fin_done) begin
            fin_done = 1'b1;
            chk("a_completed", 0, 32'(done_a), 32'd1);
            chk("b_completed", 1, 32'(done_b), 32'd1);
            chk("a_frames",    0, 32'(fr_done[0]), 32'd2);
            chk("a_pulses",    0, 32'(pulses[0]),  32'd2);
            chk("b_frames",    1, 32'(fr_done[1]), 32'd4);
            chk("b_pulses",    1, 32'(pulses[1]),  32'd2);
            chk("a_idle",      0, 32'({o_busy[0], o_wr[0]}), 32'd0);
            chk("b_idle",      1, 32'({o_busy[1], o_wr[1]}), 32'd0);
            $display("%0d/%0d checks passed", n_pass, n_total);
            $finish;
        end
    end

endmodule
